// File: rtl/cart_upload.sv
// HPS ioctl upload responder: serves byte reads of cartridge memory through a
// req/ack memory port, holding ioctl_wait while each fetch is outstanding.
module cart_upload #(
  parameter int          AW   = 16,
  parameter logic [7:0]  FILL = 8'hFF,
  parameter int          TMO  = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  input  logic [AW:0]   size,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_q,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   rd_count,
  output logic          err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;

  // Timeout fires at the end of the TMO-th FETCH cycle without an ack.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  logic [1:0]  state;
  logic        upload_q;
  logic [AW:0] size_q;
  logic [7:0]  tmo_cnt;

  logic        up_rise;
  logic        up_fall;
  logic        in_range;
  logic [AW:0] count_inc;

  assign up_rise   = ioctl_upload & ~upload_q;
  assign up_fall   = ~ioctl_upload & upload_q;
  assign in_range  = (ioctl_addr[24:AW] == '0) &&
                     ({1'b0, ioctl_addr[AW-1:0]} < size_q);
  assign count_inc = (rd_count == '1) ? rd_count : rd_count + (AW+1)'(1);
  assign busy      = (state != S_IDLE);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      upload_q   <= 1'b0;
      size_q     <= '0;
      tmo_cnt    <= '0;
      ioctl_din  <= FILL;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      done       <= 1'b0;
      rd_count   <= '0;
      err        <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (up_rise) begin
            size_q   <= size;
            rd_count <= '0;
            err      <= 1'b0;
            state    <= S_ARMED;
          end
        end

        S_ARMED: begin
          // Session end takes priority over a coincident read strobe.
          if (up_fall) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else if (ioctl_rd) begin
            if (in_range) begin
              mem_addr   <= ioctl_addr[AW-1:0];
              mem_req    <= 1'b1;
              ioctl_wait <= 1'b1;
              tmo_cnt    <= '0;
              state      <= S_FETCH;
            end else begin
              ioctl_din <= FILL;
              rd_count  <= count_inc;
            end
          end
        end

        S_FETCH: begin
          if (up_fall) begin
            // Abort: data of a coincident ack is discarded, ioctl_din kept.
            mem_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            done       <= 1'b1;
            state      <= S_IDLE;
          end else begin
            if (ioctl_rd) err <= 1'b1;
            if (mem_ack) begin
              ioctl_din  <= mem_q;
              mem_req    <= 1'b0;
              ioctl_wait <= 1'b0;
              rd_count   <= count_inc;
              state      <= S_ARMED;
            end else if (tmo_cnt == TMO_LAST) begin
              ioctl_din  <= FILL;
              err        <= 1'b1;
              mem_req    <= 1'b0;
              ioctl_wait <= 1'b0;
              rd_count   <= count_inc;
              state      <= S_ARMED;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cart_upload.sv
// Directed bench for cart_upload: reset, normal/out-of-range reads, timeout,
// overrun, abort and asynchronous reset during a fetch.
module tb_cart_upload;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [16:0] size;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_q;
  logic        busy;
  logic        done;
  logic [16:0] rd_count;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  cart_upload #(.AW(16), .FILL(8'hFF), .TMO(255)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .size         (size),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_q        (mem_q),
    .busy         (busy),
    .done         (done),
    .rd_count     (rd_count),
    .err          (err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_session(input logic [16:0] sz);
    size         = sz;
    ioctl_upload = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL end_done_busy: got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL end_done_pulse: got %b want 0", done); end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0 || mem_req !== 1'b0 ||
        mem_addr !== 16'h0 || busy !== 1'b0 || done !== 1'b0 ||
        rd_count !== 17'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got din=%h wait=%b req=%b addr=%h busy=%b done=%b cnt=%0d err=%b want din=ff all others 0",
               tag, ioctl_din, ioctl_wait, mem_req, mem_addr, busy, done, rd_count, err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset_values");
    reset_n = 1'b1;
    tick();
    check_reset_values("reset_idle_after_release");
  endtask

  task automatic test_normal();
    int wait_cycles;
    start_session(17'd4096);
    ioctl_addr = 25'h0123;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0123) begin
      n_fail++; $display("FAIL normal_req: got req=%b addr=%h want req=1 addr=0123", mem_req, mem_addr);
    end
    wait_cycles = (ioctl_wait === 1'b1) ? 1 : 0;
    tick();
    if (ioctl_wait === 1'b1) wait_cycles++;
    tick();
    if (ioctl_wait === 1'b1) wait_cycles++;
    mem_ack = 1'b1;
    mem_q   = 8'h5A;
    tick();
    mem_ack = 1'b0;
    if (ioctl_wait === 1'b1) wait_cycles++;
    n_checks++;
    if (wait_cycles != 3) begin n_fail++; $display("FAIL normal_wait_len: got %0d want 3", wait_cycles); end
    n_checks++;
    if (ioctl_din !== 8'h5A || ioctl_wait !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL normal_data: got din=%h wait=%b req=%b want din=5a wait=0 req=0",
                         ioctl_din, ioctl_wait, mem_req);
    end
    n_checks++;
    if (rd_count !== 17'd1 || err !== 1'b0) begin
      n_fail++; $display("FAIL normal_count: got cnt=%0d err=%b want cnt=1 err=0", rd_count, err);
    end
    end_session();
  endtask

  task automatic test_out_of_range();
    start_session(17'd2048);
    ioctl_addr = 25'h0800;
    ioctl_rd   = 1'b1;
    tick();
    n_checks++;
    if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0 || mem_req !== 1'b0 || rd_count !== 17'd1) begin
      n_fail++; $display("FAIL oor_0800: got din=%h wait=%b req=%b cnt=%0d want ff 0 0 1",
                         ioctl_din, ioctl_wait, mem_req, rd_count);
    end
    ioctl_addr = 25'h10000;
    tick();
    ioctl_rd = 1'b0;
    n_checks++;
    if (ioctl_din !== 8'hFF || ioctl_wait !== 1'b0 || mem_req !== 1'b0 ||
        rd_count !== 17'd2 || err !== 1'b0) begin
      n_fail++; $display("FAIL oor_10000: got din=%h wait=%b req=%b cnt=%0d err=%b want ff 0 0 2 0",
                         ioctl_din, ioctl_wait, mem_req, rd_count, err);
    end
    // Last in-range address, acknowledged one cycle after the request.
    ioctl_addr = 25'h07FF;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h07FF) begin
      n_fail++; $display("FAIL oor_edge_req: got req=%b addr=%h want req=1 addr=07ff", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_q   = 8'hA7;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (ioctl_din !== 8'hA7 || rd_count !== 17'd3) begin
      n_fail++; $display("FAIL oor_edge_data: got din=%h cnt=%0d want din=a7 cnt=3", ioctl_din, rd_count);
    end
    end_session();
  endtask

  task automatic test_timeout();
    int wait_cycles;
    start_session(17'd4096);
    ioctl_addr = 25'h0010;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd    = 1'b0;
    wait_cycles = (ioctl_wait === 1'b1) ? 1 : 0;
    for (int i = 0; i < 400 && ioctl_wait === 1'b1; i++) begin
      tick();
      if (ioctl_wait === 1'b1) wait_cycles++;
    end
    n_checks++;
    if (wait_cycles != 255) begin n_fail++; $display("FAIL timeout_len: got %0d want 255", wait_cycles); end
    n_checks++;
    if (ioctl_din !== 8'hFF || err !== 1'b0 + 1'b1 || rd_count !== 17'd1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_result: got din=%h err=%b cnt=%0d req=%b want ff 1 1 0",
                         ioctl_din, err, rd_count, mem_req);
    end
    repeat (10) tick();
    mem_ack = 1'b1;
    mem_q   = 8'h77;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (ioctl_din !== 8'hFF || rd_count !== 17'd1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_late_ack: got din=%h cnt=%0d req=%b want ff 1 0",
                         ioctl_din, rd_count, mem_req);
    end
    end_session();
  endtask

  task automatic test_overrun();
    start_session(17'd4096);
    ioctl_addr = 25'h0020;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_addr = 25'h0030;
    tick();
    ioctl_rd = 1'b0;
    n_checks++;
    if (err !== 1'b1 || mem_addr !== 16'h0020 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL overrun_err: got err=%b addr=%h req=%b want 1 0020 1", err, mem_addr, mem_req);
    end
    mem_ack = 1'b1;
    mem_q   = 8'hC3;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (ioctl_din !== 8'hC3 || rd_count !== 17'd1 || ioctl_wait !== 1'b0) begin
      n_fail++; $display("FAIL overrun_complete: got din=%h cnt=%0d wait=%b want c3 1 0",
                         ioctl_din, rd_count, ioctl_wait);
    end
    end_session();
  endtask

  task automatic test_abort();
    start_session(17'd4096);
    ioctl_addr = 25'h0040;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    mem_ack  = 1'b1;
    mem_q    = 8'h11;
    tick();
    mem_ack    = 1'b0;
    ioctl_addr = 25'h0041;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd     = 1'b0;
    mem_ack      = 1'b1;
    mem_q        = 8'h33;
    ioctl_upload = 1'b0;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (ioctl_din !== 8'h11 || rd_count !== 17'd1) begin
      n_fail++; $display("FAIL abort_data: got din=%h cnt=%0d want din=11 cnt=1", ioctl_din, rd_count);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || ioctl_wait !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl: got done=%b busy=%b req=%b wait=%b want 1 0 0 0",
                         done, busy, mem_req, ioctl_wait);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset_mid_fetch();
    start_session(17'd4096);
    ioctl_addr = 25'h0055;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_req: got %b want 1", mem_req); end
    #2;
    reset_n      = 1'b0;
    ioctl_upload = 1'b0;
    #1;
    check_reset_values("rst_mid_fetch");
    #1;
    reset_n = 1'b1;
    tick();
    check_reset_values("rst_mid_fetch_idle");
  endtask

  initial begin
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    size         = '0;
    mem_ack      = 1'b0;
    mem_q        = '0;
    test_reset();
    test_normal();
    test_out_of_range();
    test_timeout();
    test_overrun();
    test_abort();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
